// File: rtl/psum_issue_pkg.sv
// psum_issue_pkg: shared sizes and state encoding for the accumulator psum
// issue block (psum_issue) and its burst buffer (psum_burst_buf).
package psum_issue_pkg;
  localparam int WEIGHT_SIZE   = 3;
  localparam int DATA_WIDTH    = 8;
  localparam int BIAS_WIDTH    = 32;
  localparam int FC_WCOL_WIDTH = 5;
  localparam int DEPTH         = 16;
  localparam int TIMEOUT       = 15;

  localparam int LANE_W = 2*DATA_WIDTH + 2;
  localparam int PSUM_W = WEIGHT_SIZE * LANE_W;
  localparam int AW     = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;
  localparam logic [2:0] ST_CLEAR = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_FILL  = ST_FILL,
    S_DRAIN = ST_DRAIN,
    S_GAP   = ST_GAP,
    S_FIN   = ST_FIN,
    S_CLEAR = ST_CLEAR
  } state_t;
endpackage

// File: rtl/psum_burst_buf.sv
// psum_burst_buf: DEPTH-entry FIFO holding one lane-packed psum burst.
// Ports: clk/rst_n, i_clear (sync flush), i_wr_en/i_wr_data (push),
// i_rd_en (pop), o_rd_data (head entry, combinational), o_count, o_full.
// DEPTH is a power of two, so the pointers wrap by natural overflow.
module psum_burst_buf
  import psum_issue_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_wr_en,
  input  logic [PSUM_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  output logic [PSUM_W-1:0] o_rd_data,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full
);
  localparam logic [AW-1:0]    PTR_ONE = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [PSUM_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_wr;
  logic              w_rd;

  assign w_wr      = i_wr_en && !o_full;
  assign w_rd      = i_rd_en && (r_count != '0);
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_full    = (r_count == CNT_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/psum_issue.sv
// psum_issue: transmit side of the accumulator psum interface.
// Accepts a job (i_job_*), buffers each psum burst (i_ps_*) completely and
// replays it gap-free on o_acc_enable/o_acc_psum, then waits for the
// accumulator (i_acc_fc_line_done / i_acc_fc_done) before the next burst or
// job end. o_job_done pulses at job end; o_err is sticky until the next accept.
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; ready never depends on valid.
// Debug: o_dbg_state (FSM state), o_dbg_conv_seen (CONV result strobe seen
// since the last job accept).
module psum_issue
  import psum_issue_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_job_valid,
  output logic                     o_job_ready,
  input  logic                     i_job_layer,
  input  logic [FC_WCOL_WIDTH-1:0] i_job_fc_wcol,
  input  logic [BIAS_WIDTH-1:0]    i_job_bias,
  input  logic                     i_ps_valid,
  output logic                     o_ps_ready,
  input  logic [PSUM_W-1:0]        i_ps_data,
  input  logic                     i_ps_last,
  output logic                     o_acc_enable,
  output logic                     o_acc_layer,
  output logic [PSUM_W-1:0]        o_acc_psum,
  output logic [BIAS_WIDTH-1:0]    o_acc_bias,
  output logic [FC_WCOL_WIDTH-1:0] o_acc_fc_wcol,
  input  logic                     i_acc_conv_comp,
  input  logic                     i_acc_fc_line_done,
  input  logic                     i_acc_fc_done,
  output logic                     o_job_done,
  output logic                     o_err,
  output logic [2:0]               o_dbg_state,
  output logic                     o_dbg_conv_seen
);
  state_t                   r_state, w_state_nxt;
  logic                     r_job_ready;
  logic                     r_layer;
  logic [FC_WCOL_WIDTH-1:0] r_burst_cnt;
  logic [TMR_W-1:0]         r_tmr;
  logic                     r_line_seen;
  logic                     r_acc_enable;
  logic                     r_acc_layer;
  logic [PSUM_W-1:0]        r_acc_psum;
  logic [BIAS_WIDTH-1:0]    r_acc_bias;
  logic [FC_WCOL_WIDTH-1:0] r_acc_fc_wcol;
  logic                     r_job_done;
  logic                     r_err;
  logic                     r_conv_seen;

  logic              w_accept, w_push, w_pop, w_flush, w_set_err;
  logic              w_burst_inc, w_done, w_ps_ready, w_line;
  logic [PSUM_W-1:0] w_rd_data;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;

  psum_burst_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_flush),
    .i_wr_en   (w_push),
    .i_wr_data (i_ps_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_rd_data),
    .o_count   (w_count),
    .o_full    (w_full)
  );

  // line_done is a single-cycle pulse that may land before the minimum gap
  // has elapsed, so it is remembered for the rest of the GAP state.
  assign w_line = i_acc_fc_line_done || r_line_seen;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_flush     = 1'b0;
    w_set_err   = 1'b0;
    w_burst_inc = 1'b0;
    w_done      = 1'b0;
    w_ps_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_job_ready && i_job_valid) begin
          w_accept = 1'b1;
          if (i_job_layer && (i_job_fc_wcol == '0)) begin
            w_set_err = 1'b1;
            w_done    = 1'b1;
          end else begin
            w_state_nxt = S_FILL;
          end
        end
      end
      S_FILL: begin
        w_ps_ready = !w_full;
        if (i_ps_valid && w_ps_ready) begin
          w_push = 1'b1;
          if (i_ps_last) begin
            w_state_nxt = S_DRAIN;
          end else if (w_count == CNT_W'(DEPTH - 1)) begin
            // Last slot taken without ps_last: the burst cannot fit.
            w_set_err   = 1'b1;
            w_flush     = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        w_pop = 1'b1;
        if (w_count == CNT_W'(1)) begin
          w_burst_inc = 1'b1;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (!r_layer) begin
          if (r_tmr == TMR_W'(1)) w_state_nxt = S_FIN;
        end else if (w_line && (r_tmr != '0)) begin
          w_state_nxt = (r_burst_cnt < r_acc_fc_wcol) ? S_FILL : S_FIN;
        end else if (r_tmr == TMR_W'(TIMEOUT - 1)) begin
          w_set_err   = 1'b1;
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        if (!r_layer || i_acc_fc_done) begin
          w_done      = 1'b1;
          w_state_nxt = S_CLEAR;
        end else if (r_tmr == TMR_W'(TIMEOUT - 1)) begin
          w_set_err   = 1'b1;
          w_done      = 1'b1;
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_job_ready   <= 1'b0;
      r_layer       <= 1'b0;
      r_burst_cnt   <= '0;
      r_tmr         <= '0;
      r_line_seen   <= 1'b0;
      r_acc_enable  <= 1'b0;
      r_acc_layer   <= 1'b0;
      r_acc_psum    <= '0;
      r_acc_bias    <= '0;
      r_acc_fc_wcol <= '0;
      r_job_done    <= 1'b0;
      r_err         <= 1'b0;
      r_conv_seen   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_job_ready <= (w_state_nxt == S_IDLE);
      r_job_done  <= w_done;

      if (w_accept) begin
        r_layer       <= i_job_layer;
        r_acc_bias    <= i_job_bias;
        r_acc_fc_wcol <= i_job_fc_wcol;
        r_burst_cnt   <= '0;
      end else if (w_burst_inc) begin
        r_burst_cnt <= r_burst_cnt + FC_WCOL_WIDTH'(1);
      end

      if (w_set_err)     r_err <= 1'b1;
      else if (w_accept) r_err <= 1'b0;

      if (w_accept)             r_conv_seen <= 1'b0;
      else if (i_acc_conv_comp) r_conv_seen <= 1'b1;

      // acc_layer low in CLEAR releases the accumulator's FC done hold.
      if ((w_state_nxt == S_CLEAR) || (w_state_nxt == S_IDLE)) r_acc_layer <= 1'b0;
      else if (w_accept)                                       r_acc_layer <= i_job_layer;

      if (w_state_nxt != r_state)                    r_tmr <= '0;
      else if ((r_state == S_GAP) || (r_state == S_FIN)) r_tmr <= r_tmr + TMR_W'(1);

      if (w_state_nxt != r_state)                           r_line_seen <= 1'b0;
      else if ((r_state == S_GAP) && i_acc_fc_line_done) r_line_seen <= 1'b1;

      r_acc_enable <= (r_state == S_DRAIN);
      r_acc_psum   <= (r_state == S_DRAIN) ? w_rd_data : '0;
    end
  end

  assign o_job_ready     = r_job_ready;
  assign o_ps_ready      = w_ps_ready;
  assign o_acc_enable    = r_acc_enable;
  assign o_acc_layer     = r_acc_layer;
  assign o_acc_psum      = r_acc_psum;
  assign o_acc_bias      = r_acc_bias;
  assign o_acc_fc_wcol   = r_acc_fc_wcol;
  assign o_job_done      = r_job_done;
  assign o_err           = r_err;
  assign o_dbg_state     = r_state;
  assign o_dbg_conv_seen = r_conv_seen;
endmodule

// File: tb/tb_psum_issue.sv
// tb_psum_issue: randomized and directed jobs against psum_issue with an
// accumulator model; beats expected on acc_psum are queued as they are sent.
module tb_psum_issue;
  import psum_issue_pkg::*;

  logic                     clk, rst_n;
  logic                     job_valid, job_ready, job_layer;
  logic [FC_WCOL_WIDTH-1:0] job_fc_wcol;
  logic [BIAS_WIDTH-1:0]    job_bias;
  logic                     ps_valid, ps_ready, ps_last;
  logic [PSUM_W-1:0]        ps_data;
  logic                     acc_enable, acc_layer;
  logic [PSUM_W-1:0]        acc_psum;
  logic [BIAS_WIDTH-1:0]    acc_bias;
  logic [FC_WCOL_WIDTH-1:0] acc_fc_wcol;
  logic                     acc_conv_comp, acc_fc_line_done, acc_fc_done;
  logic                     job_done, err, dbg_conv_seen;
  logic [2:0]               dbg_state;

  psum_issue dut (
    .clk(clk), .rst_n(rst_n),
    .i_job_valid(job_valid), .o_job_ready(job_ready), .i_job_layer(job_layer),
    .i_job_fc_wcol(job_fc_wcol), .i_job_bias(job_bias),
    .i_ps_valid(ps_valid), .o_ps_ready(ps_ready), .i_ps_data(ps_data), .i_ps_last(ps_last),
    .o_acc_enable(acc_enable), .o_acc_layer(acc_layer), .o_acc_psum(acc_psum),
    .o_acc_bias(acc_bias), .o_acc_fc_wcol(acc_fc_wcol),
    .i_acc_conv_comp(acc_conv_comp), .i_acc_fc_line_done(acc_fc_line_done),
    .i_acc_fc_done(acc_fc_done), .o_job_done(job_done), .o_err(err),
    .o_dbg_state(dbg_state), .o_dbg_conv_seen(dbg_conv_seen)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [PSUM_W:0]          exp_q[$];   // {last, beat}
  logic                     exp_layer;
  logic [BIAS_WIDTH-1:0]    exp_bias;
  logic [FC_WCOL_WIDTH-1:0] exp_wcol;
  int                       n_checks = 0;
  int                       n_fail = 0;
  int                       done_cnt = 0;
  int                       bursts_obs = 0;
  logic                     model_line_en = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic            mon_prev_en = 1'b0;
  logic            mon_prev_last = 1'b1;
  logic            mon_prev_done = 1'b0;
  logic [PSUM_W:0] mon_item;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_prev_en   = 1'b0;
      mon_prev_last = 1'b1;
      mon_prev_done = 1'b0;
    end else begin
      if (acc_enable) begin
        if (!mon_prev_en) bursts_obs++;
        if (mon_prev_en && mon_prev_last) check("burst_end_low", acc_enable, 1'b0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL beat_unexpected: got %0h expected none", acc_psum);
        end else begin
          mon_item = exp_q.pop_front();
          check("acc_psum", acc_psum, mon_item[PSUM_W-1:0]);
          mon_prev_last = mon_item[PSUM_W];
        end
        check("acc_layer_burst", acc_layer, exp_layer);
        check("acc_bias", acc_bias, exp_bias);
        check("acc_fc_wcol", acc_fc_wcol, exp_wcol);
      end else begin
        check("acc_psum_idle_zero", acc_psum, '0);
        if (mon_prev_en && !mon_prev_last) check("burst_gap_free", acc_enable, 1'b1);
      end
      if (job_done) begin
        done_cnt++;
        check("acc_layer_in_clear", acc_layer, 1'b0);
        check("job_done_one_cycle", mon_prev_done, 1'b0);
      end
      mon_prev_en   = acc_enable;
      mon_prev_done = job_done;
    end
  end

  // ---------------- accumulator model ----------------
  // Responds 2 cycles after acc_enable falls: line_done pulse for FC (and
  // fc_done level after the last column), conv_comp pulse for CONV.
  initial begin
    int   m_cd;
    int   m_lines;
    logic m_prev_en;
    logic m_is_fc;
    acc_conv_comp = 1'b0; acc_fc_line_done = 1'b0; acc_fc_done = 1'b0;
    m_cd = 0; m_lines = 0; m_prev_en = 1'b0; m_is_fc = 1'b0;
    forever begin
      @(posedge clk); #1;
      acc_fc_line_done = 1'b0;
      acc_conv_comp    = 1'b0;
      if (!rst_n) begin
        m_cd = 0; m_lines = 0; acc_fc_done = 1'b0;
      end else begin
        if (m_prev_en && !acc_enable) begin
          m_cd    = 2;
          m_is_fc = acc_layer;
        end else if (m_cd != 0) begin
          m_cd--;
          if (m_cd == 0) begin
            if (!m_is_fc) acc_conv_comp = 1'b1;
            else if (model_line_en) begin
              acc_fc_line_done = 1'b1;
              m_lines++;
              if (m_lines == int'(exp_wcol)) acc_fc_done = 1'b1;
            end
          end
        end
        if (!acc_layer && !acc_fc_line_done) begin
          acc_fc_done = 1'b0;
          m_lines     = 0;
        end
      end
      m_prev_en = acc_enable;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic accept_job(input logic layer, input logic [FC_WCOL_WIDTH-1:0] wcol,
                            input logic [BIAS_WIDTH-1:0] bias);
    int g = 0;
    job_layer = layer; job_fc_wcol = wcol; job_bias = bias; job_valid = 1'b1;
    while (!job_ready && g < 200) begin @(negedge clk); g++; end
    check("job_ready_seen", job_ready, 1'b1);
    exp_layer = layer; exp_bias = bias; exp_wcol = wcol;
    @(posedge clk); @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [PSUM_W-1:0] d, input logic last,
                           input bit stall, input bit expect_out);
    int g = 0;
    if (stall && $urandom_range(0, 2) == 0) begin
      ps_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    ps_valid = 1'b1; ps_data = d; ps_last = last;
    while (!ps_ready && g < 200) begin @(negedge clk); g++; end
    if (!ps_ready) begin
      check("ps_ready_timeout", ps_ready, 1'b1);
    end else begin
      if (expect_out) exp_q.push_back({last, d});
      @(posedge clk); @(negedge clk);
    end
    ps_valid = 1'b0; ps_last = 1'b0;
  endtask

  function automatic logic [PSUM_W-1:0] rand_beat();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[PSUM_W-1:0];
  endfunction

  task automatic send_burst(input int n, input bit stall);
    for (int i = 0; i < n; i++) send_beat(rand_beat(), (i == n - 1), stall, 1'b1);
  endtask

  task automatic wait_done(input int start, input int budget);
    int g = 0;
    while (done_cnt == start && g < budget) begin @(negedge clk); g++; end
    repeat (3) @(negedge clk);
    check("job_done_count", done_cnt - start, 1);
  endtask

  task automatic run_job(input logic layer, input logic [FC_WCOL_WIDTH-1:0] wcol,
                         input int beats, input bit stall);
    int b0, d0, nb;
    b0 = bursts_obs; d0 = done_cnt;
    nb = layer ? int'(wcol) : 1;
    accept_job(layer, wcol, $urandom());
    check("err_cleared_on_accept", err, 1'b0);
    for (int b = 0; b < nb; b++) send_burst((beats == 0) ? $urandom_range(1, DEPTH) : beats, stall);
    wait_done(d0, 600);
    check("err_after_job", err, 1'b0);
    check("bursts_in_job", bursts_obs - b0, nb);
    check("exp_q_empty", exp_q.size(), 0);
    check("state_idle", dbg_state, ST_IDLE);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [PSUM_W-1:0] beat;
    int b0, d0;
    rst_n = 1'b0; job_valid = 1'b0; job_layer = 1'b0; job_fc_wcol = '0; job_bias = '0;
    ps_valid = 1'b0; ps_data = '0; ps_last = 1'b0;
    exp_layer = 1'b0; exp_bias = '0; exp_wcol = '0;
    repeat (3) @(negedge clk);
    check("rst_job_ready", job_ready, 1'b0);
    check("rst_ps_ready", ps_ready, 1'b0);
    check("rst_acc_enable", acc_enable, 1'b0);
    check("rst_acc_layer", acc_layer, 1'b0);
    check("rst_acc_psum", acc_psum, '0);
    check("rst_acc_bias", acc_bias, '0);
    check("rst_acc_fc_wcol", acc_fc_wcol, '0);
    check("rst_job_done", job_done, 1'b0);
    check("rst_err", err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("job_ready_after_rst", job_ready, 1'b1);

    // Directed CONV: 4 beats of lanes {1,2,3}, bias 5.
    b0 = bursts_obs; d0 = done_cnt;
    accept_job(1'b0, 5'd0, 32'd5);
    beat = {18'd3, 18'd2, 18'd1};
    for (int i = 0; i < 4; i++) send_beat(beat, (i == 3), 1'b0, 1'b1);
    wait_done(d0, 200);
    repeat (4) @(negedge clk);
    check("conv_bursts", bursts_obs - b0, 1);
    check("conv_comp_seen", dbg_conv_seen, 1'b1);
    check("conv_err", err, 1'b0);

    // Directed FC: 3 bursts of 2 beats.
    run_job(1'b1, 5'd3, 2, 1'b0);

    // Randomized jobs with upstream stalls.
    for (int j = 0; j < 8; j++)
      run_job($urandom_range(0, 1), FC_WCOL_WIDTH'($urandom_range(1, 4)), 0, 1'b1);

    // Overflow: 16 beats without ps_last.
    b0 = bursts_obs; d0 = done_cnt;
    accept_job(1'b0, 5'd1, $urandom());
    for (int i = 0; i < DEPTH; i++) send_beat(rand_beat(), 1'b0, 1'b0, 1'b0);
    ps_valid = 1'b1; ps_data = rand_beat();
    repeat (4) @(negedge clk);
    check("ovf_17th_not_ready", ps_ready, 1'b0);
    ps_valid = 1'b0;
    check("ovf_err", err, 1'b1);
    check("ovf_state_idle", dbg_state, ST_IDLE);
    check("ovf_no_enable", bursts_obs - b0, 0);
    check("ovf_no_done", done_cnt - d0, 0);
    run_job(1'b0, 5'd2, 3, 1'b0);

    // FC with no line_done: timeout error, job still completes.
    model_line_en = 1'b0;
    b0 = bursts_obs; d0 = done_cnt;
    accept_job(1'b1, 5'd2, $urandom());
    send_burst(3, 1'b0);
    wait_done(d0, 200);
    check("tmo_err", err, 1'b1);
    check("tmo_bursts", bursts_obs - b0, 1);
    model_line_en = 1'b1;

    // FC with zero columns: immediate error and done.
    d0 = done_cnt;
    accept_job(1'b1, 5'd0, $urandom());
    check("wcol0_done", job_done, 1'b1);
    check("wcol0_err", err, 1'b1);
    check("wcol0_layer", acc_layer, 1'b0);
    @(negedge clk);
    check("wcol0_done_count", done_cnt - d0, 1);

    // Reset in the middle of a drain.
    accept_job(1'b0, 5'd0, $urandom());
    send_burst(10, 1'b0);
    repeat (3) @(negedge clk);
    check("pre_rst_enable", acc_enable, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("rst_async_enable", acc_enable, 1'b0);
    check("rst_async_psum", acc_psum, '0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_state", dbg_state, ST_IDLE);
    check("post_rst_ready", job_ready, 1'b1);
    run_job(1'b1, 5'd2, 4, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end
endmodule
